// File: rtl/shiftout_serializer.sv
// -----------------------------------------------------------------------------
// shiftout_serializer
//
// Serial shifter for 74HC595-style shift-register chains. A start pulse in IDLE
// captures a DATA_WIDTH-bit word. The word is shifted out on data_out, framed by
// clk_out, either MSB- or LSB-first. Each clk_out half-period lasts CLK_DIV
// clk_in cycles. After the last bit, latch_out rises to transfer the word into
// the storage registers, and done_out pulses for one cycle.
//
// Parameters
//   DATA_WIDTH : bits per transfer (>= 1; 8 x number of cascaded '595s)
//   CLK_DIV    : clk_in cycles per half-period of clk_out (>= 1)
//   MSB_FIRST  : 1 = data_in[DATA_WIDTH-1] first, 0 = data_in[0] first
//
// Ports
//   clk_in    in   system clock, all logic on its rising edge
//   reset_in  in   asynchronous active-high reset
//   start_in  in   start request, only honoured in IDLE
//   data_in   in   word to send, captured on the accepting edge
//   clk_out   out  shift clock to the register chain
//   data_out  out  serial data, stable across every clk_out rising edge
//   latch_out out  storage latch; low while shifting, its rising edge latches
//   busy_out  out  high from accept until completion
//   done_out  out  one-cycle completion pulse
// -----------------------------------------------------------------------------
module shiftout_serializer #(
  parameter int DATA_WIDTH = 16,
  parameter int CLK_DIV    = 1,
  parameter bit MSB_FIRST  = 1'b1
) (
  input  logic                  clk_in,
  input  logic                  reset_in,
  input  logic                  start_in,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic                  clk_out,
  output logic                  data_out,
  output logic                  latch_out,
  output logic                  busy_out,
  output logic                  done_out
);

  // A CLK_DIV of 1 would give a zero-width divider; keep at least one bit.
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  // Wide enough to hold DATA_WIDTH itself (bits already clocked).
  localparam int CNT_W = $clog2(DATA_WIDTH + 1);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT_LO,
    SHIFT_HI
  } state_t;

  state_t                state, state_next;
  logic [DIV_W-1:0]      div_cnt, div_next;
  logic [CNT_W-1:0]      bit_cnt, bit_next;
  logic [DATA_WIDTH-1:0] shreg, shreg_next;
  logic                  clk_next, data_next, latch_next, busy_next, done_next;

  // Bit that is presented first from a word in the current orientation.
  function automatic logic first_bit(input logic [DATA_WIDTH-1:0] w);
    return MSB_FIRST ? w[DATA_WIDTH-1] : w[0];
  endfunction

  // Discard the bit just sent so the next one sits at the output end.
  function automatic logic [DATA_WIDTH-1:0] advance(input logic [DATA_WIDTH-1:0] w);
    return MSB_FIRST ? (w << 1) : (w >> 1);
  endfunction

  // ---------------------------------------------------------------------------
  // State register. All outputs are registered so the pins are glitch-free and
  // their reset values appear as soon as reset_in rises.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      state     <= IDLE;
      div_cnt   <= '0;
      bit_cnt   <= '0;
      shreg     <= '0;
      clk_out   <= 1'b0;
      data_out  <= 1'b0;
      latch_out <= 1'b1;
      busy_out  <= 1'b0;
      done_out  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments give every register its pre-edge view
      // of the others, so the ordering of these lines is irrelevant.
      state     <= state_next;
      div_cnt   <= div_next;
      bit_cnt   <= bit_next;
      shreg     <= shreg_next;
      clk_out   <= clk_next;
      data_out  <= data_next;
      latch_out <= latch_next;
      busy_out  <= busy_next;
      done_out  <= done_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and next-output logic.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal gets a hold/default value first. A path that forgets
    // to assign a signal therefore keeps its value instead of inferring a latch.
    state_next = state;
    div_next   = div_cnt;
    bit_next   = bit_cnt;
    shreg_next = shreg;
    clk_next   = clk_out;
    data_next  = data_out;
    latch_next = latch_out;
    busy_next  = busy_out;
    done_next  = 1'b0;   // done is a single-cycle pulse

    unique case (state)
      IDLE: begin
        clk_next   = 1'b0;
        data_next  = 1'b0;
        latch_next = 1'b1;
        busy_next  = 1'b0;
        div_next   = '0;
        bit_next   = '0;
        if (start_in) begin
          // Present the first bit now. It is then stable for a full CLK_DIV
          // low phase before the first clk_out rising edge.
          shreg_next = data_in;
          data_next  = first_bit(data_in);
          latch_next = 1'b0;
          busy_next  = 1'b1;
          state_next = SHIFT_LO;
        end
      end

      SHIFT_LO: begin
        if (div_cnt == DIV_LAST) begin
          clk_next   = 1'b1;
          div_next   = '0;
          state_next = SHIFT_HI;
        end else begin
          div_next = div_cnt + 1'b1;
        end
      end

      SHIFT_HI: begin
        if (div_cnt == DIV_LAST) begin
          // Falling edge of clk_out: the only point, besides accept, where
          // data_out may change. This keeps hold time symmetric with setup.
          clk_next = 1'b0;
          div_next = '0;
          bit_next = bit_cnt + 1'b1;
          if (bit_cnt == BIT_LAST) begin
            data_next  = 1'b0;
            latch_next = 1'b1;
            busy_next  = 1'b0;
            done_next  = 1'b1;
            state_next = IDLE;
          end else begin
            shreg_next = advance(shreg);
            data_next  = first_bit(advance(shreg));
            state_next = SHIFT_LO;
          end
        end else begin
          div_next = div_cnt + 1'b1;
        end
      end

      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_shiftout_serializer.sv
// -----------------------------------------------------------------------------
// tb_shiftout_serializer
//
// Directed bench for shiftout_serializer. It uses three instances:
//   a : DATA_WIDTH=16, CLK_DIV=1, MSB_FIRST=1
//   b : DATA_WIDTH=16, CLK_DIV=1, MSB_FIRST=0
//   c : DATA_WIDTH=8,  CLK_DIV=3, MSB_FIRST=1
// A select variable routes the shared stimulus to one instance and its outputs
// to the monitor. Inputs are driven and outputs sampled 1 time unit after each
// rising clock edge.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_shiftout_serializer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [15:0] data = '0;
  int          sel = 0;

  logic start_a, start_b, start_c;
  logic a_clk, a_data, a_latch, a_busy, a_done;
  logic b_clk, b_data, b_latch, b_busy, b_done;
  logic c_clk, c_data, c_latch, c_busy, c_done;
  logic m_clk, m_data, m_latch, m_busy, m_done;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign start_a = start && (sel == 0);
  assign start_b = start && (sel == 1);
  assign start_c = start && (sel == 2);

  assign m_clk   = (sel == 0) ? a_clk   : (sel == 1) ? b_clk   : c_clk;
  assign m_data  = (sel == 0) ? a_data  : (sel == 1) ? b_data  : c_data;
  assign m_latch = (sel == 0) ? a_latch : (sel == 1) ? b_latch : c_latch;
  assign m_busy  = (sel == 0) ? a_busy  : (sel == 1) ? b_busy  : c_busy;
  assign m_done  = (sel == 0) ? a_done  : (sel == 1) ? b_done  : c_done;

  shiftout_serializer #(.DATA_WIDTH(16), .CLK_DIV(1), .MSB_FIRST(1'b1)) dut_a (
    .clk_in(clk), .reset_in(rst), .start_in(start_a), .data_in(data),
    .clk_out(a_clk), .data_out(a_data), .latch_out(a_latch),
    .busy_out(a_busy), .done_out(a_done)
  );

  shiftout_serializer #(.DATA_WIDTH(16), .CLK_DIV(1), .MSB_FIRST(1'b0)) dut_b (
    .clk_in(clk), .reset_in(rst), .start_in(start_b), .data_in(data),
    .clk_out(b_clk), .data_out(b_data), .latch_out(b_latch),
    .busy_out(b_busy), .done_out(b_done)
  );

  shiftout_serializer #(.DATA_WIDTH(8), .CLK_DIV(3), .MSB_FIRST(1'b1)) dut_c (
    .clk_in(clk), .reset_in(rst), .start_in(start_c), .data_in(data[7:0]),
    .clk_out(c_clk), .data_out(c_data), .latch_out(c_latch),
    .busy_out(c_busy), .done_out(c_done)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Run one transfer on instance s and monitor it until done_out (bounded).
  // exp_seq holds the bits sampled on clk_out rises, first bit in the MSB
  // position of the width-bit sequence. exp_done is the cycle of done relative
  // to the accept edge. If poke_at >= 0, a second start with 16'hFFFF is
  // pulsed at that cycle.
  task automatic run_xfer(input int s, input logic [15:0] word, input int width,
                          input int div, input int poke_at, input logic [15:0] exp_seq,
                          input int exp_done, input string tag);
    logic [15:0] seq;
    int rises, busy_n, done_at, run;
    bit latch_bad, phase_bad, data_bad;
    logic pclk, pdata;
    sel   = s;
    data  = word;
    start = 1'b1;
    tick();             // now at accept edge E0
    start = 1'b0;
    data  = ~word;      // must not disturb the transfer in progress
    seq = '0; rises = 0; busy_n = 0; done_at = -1; run = 0;
    latch_bad = 1'b0; phase_bad = 1'b0; data_bad = 1'b0;
    pclk = m_clk; pdata = m_data;
    for (int k = 0; k < 300; k++) begin
      if (k == poke_at) begin
        data  = 16'hFFFF;
        start = 1'b1;
      end else if (poke_at >= 0 && k == poke_at + 1) begin
        start = 1'b0;
        data  = ~word;
      end
      if (m_busy) busy_n++;
      if (!m_done && m_latch) latch_bad = 1'b1;
      if (m_clk && !pclk) begin
        rises++;
        seq = {seq[14:0], m_data};
      end
      if (m_clk != pclk) begin
        if (run != div) phase_bad = 1'b1;
        run = 1;
      end else begin
        run++;
      end
      if (m_data != pdata && !(pclk && !m_clk)) data_bad = 1'b1;
      pclk  = m_clk;
      pdata = m_data;
      if (m_done) begin
        done_at = k;
        break;
      end
      tick();
    end
    check({tag, " bits"}, 32'(seq), 32'(exp_seq));
    check({tag, " rises"}, 32'(rises), 32'(width));
    check({tag, " done_at"}, 32'(done_at), 32'(exp_done));
    check({tag, " busy_cycles"}, 32'(busy_n), 32'(exp_done));
    check({tag, " latch_low"}, 32'(latch_bad), 32'd0);
    check({tag, " phase_len"}, 32'(phase_bad), 32'd0);
    check({tag, " data_on_fall"}, 32'(data_bad), 32'd0);
    if (done_at >= 0) begin
      check({tag, " latch_at_done"}, 32'(m_latch), 32'd1);
      tick();
      check({tag, " done_single"}, 32'(m_done), 32'd0);
      check({tag, " idle_busy"}, 32'(m_busy), 32'd0);
    end
    data = '0;
    tick();
  endtask

  initial begin
    logic [15:0] seq1, seq2;
    int d1, d2, latch_hi, rises;
    logic pclk;

    // ---------------- reset state of every instance ----------------
    rst = 1'b1;
    #1;
    for (int s = 0; s < 3; s++) begin
      sel = s;
      #1;
      check($sformatf("rst%0d clk", s),   32'(m_clk),   32'd0);
      check($sformatf("rst%0d data", s),  32'(m_data),  32'd0);
      check($sformatf("rst%0d latch", s), 32'(m_latch), 32'd1);
      check($sformatf("rst%0d busy", s),  32'(m_busy),  32'd0);
      check($sformatf("rst%0d done", s),  32'(m_done),  32'd0);
    end
    tick();
    tick();
    rst = 1'b0;
    tick();

    // ---------------- directed transfers ----------------
    run_xfer(0, 16'hA5C3, 16, 1, -1, 16'hA5C3, 32, "msb_a5c3");
    run_xfer(1, 16'h0001, 16, 1, -1, 16'h8000, 32, "lsb_0001");
    run_xfer(2, 16'h0081, 8,  3, -1, 16'h0081, 48, "div3_81");
    run_xfer(0, 16'h0000, 16, 1, 10, 16'h0000, 32, "ignore_start");

    // ---------------- back-to-back with start held high ----------------
    sel   = 0;
    data  = 16'h1234;
    start = 1'b1;
    tick();             // E0: first word accepted
    data  = 16'h5678;
    seq1 = '0; seq2 = '0; d1 = -1; d2 = -1; latch_hi = 0; rises = 0;
    pclk = m_clk;
    for (int k = 0; k < 80; k++) begin
      if (k >= 1 && k <= 64 && m_latch) latch_hi++;
      if (m_clk && !pclk) begin
        rises++;
        if (rises <= 16) seq1 = {seq1[14:0], m_data};
        else             seq2 = {seq2[14:0], m_data};
      end
      pclk = m_clk;
      if (m_done) begin
        if (d1 < 0) d1 = k;
        else if (d2 < 0) d2 = k;
      end
      if (k == 33) start = 1'b0;   // second word accepted on edge E0+33
      if (d2 >= 0) break;
      tick();
    end
    start = 1'b0;
    check("b2b word1", 32'(seq1), 32'h1234);
    check("b2b word2", 32'(seq2), 32'h5678);
    check("b2b done1", 32'(d1), 32'd32);
    check("b2b done2", 32'(d2), 32'd65);
    check("b2b latch_gap", 32'(latch_hi), 32'd1);
    tick();
    tick();
    check("b2b no_third", 32'(m_busy), 32'd0);

    // ---------------- asynchronous reset mid-transfer ----------------
    sel   = 0;
    data  = 16'hFFFF;
    start = 1'b1;
    tick();             // E0
    start = 1'b0;
    d1 = 0;
    for (int k = 0; k < 13; k++) begin
      if (m_done) d1++;
      tick();
    end
    // E0+13: clk_out high, data_out 1 -> reset must clear them between edges
    check("pre_rst clk", 32'(m_clk), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst clk",   32'(m_clk),   32'd0);
    check("async_rst data",  32'(m_data),  32'd0);
    check("async_rst latch", 32'(m_latch), 32'd1);
    check("async_rst busy",  32'(m_busy),  32'd0);
    for (int k = 0; k < 3; k++) begin
      tick();
      if (m_done) d1++;
    end
    rst = 1'b0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (m_done) d1++;
    end
    check("async_rst no_done", 32'(d1), 32'd0);
    run_xfer(0, 16'hA5C3, 16, 1, -1, 16'hA5C3, 32, "after_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
